// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master = operand source / result consumer, slave = the subtractor.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    // Both directions use the same rule: a transfer happens on a rising edge
    // where valid and ready are both high. valid never waits on ready. The
    // subtractor raises in_ready only in IDLE and out_valid only in DONE.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow, zero, ovf, busy
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin: one full-subtractor cell reused LSB first, one bit
// per clock, with valid/ready handshakes on operands and results.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_ctrl_if.slave  bus,
    output logic [1:0]               o_dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_abit;
    logic             w_bbit;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Operands shift right, so the current bit is always at position 0.
    assign w_abit     = r_a[0];
    assign w_bbit     = r_b[0];
    assign w_d        = w_abit ^ w_bbit ^ r_br;
    assign w_bo       = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_br);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_br       <= bus.bin;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_state    <= S_SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Signed overflow: borrow into the MSB differs from borrow out.
                        r_diff      <= w_res_next;
                        r_borrow    <= w_bo;
                        r_zero      <= (w_res_next == '0);
                        r_ovf       <= r_br ^ w_bo;
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign o_dbg_state   = r_state;
endmodule
